store_buffer: RTL and testbench

- Posted-write FIFO sitting directly upstream of the data memory (dm) in the MIPS datapath.
- Accepts store requests from the MEM stage and retires them to dm one word per cycle.
- Decouples the pipeline from memory write timing.
- Forwards buffered data to loads that hit a pending store, so a load never sees stale dm contents.

---
 rtl/store_buffer.sv | 85 ++++++++
 tb/tb_store_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write FIFO in front of the data memory. It retires one store per cycle
// and forwards pending store data to a load whose address matches.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [31:0]   st_addr,
  input  logic [31:0]   st_data,
  input  logic [31:0]   st_pc,
  input  logic [31:0]   ld_addr,
  output logic          ld_hit,
  output logic [31:0]   ld_data,
  input  logic          drain_en,
  output logic          MemWrite,
  output logic [31:0]   pc,
  output logic [31:0]   addr,
  output logic [31:0]   din,
  output logic [PW:0]   count,
  output logic          empty
);

  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [31:0]   ent_addr [DEPTH];
  logic [31:0]   ent_data [DEPTH];
  logic [31:0]   ent_pc   [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          enq;

  assign st_ready = (count < FULL_COUNT);
  assign empty    = (count == '0);
  assign enq      = st_valid && st_ready;
  assign MemWrite = drain_en && !empty;
  assign pc       = ent_pc[head];
  assign addr     = ent_addr[head];
  assign din      = ent_data[head];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
        ent_pc[i]   <= '0;
      end
    end else begin
      if (enq) begin
        ent_addr[tail] <= st_addr;
        ent_data[tail] <= st_data;
        ent_pc[tail]   <= st_pc;
        tail           <= tail + 1'b1;
      end
      if (MemWrite)
        head <= head + 1'b1;
      case ({enq, MemWrite})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Walk occupied entries oldest to youngest so the last match is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    ld_hit  = 1'b0;
    ld_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (((PW+1)'(i) < count) && (ent_addr[idx] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = ent_data[idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus randomized traffic, checked
// against a queue-based model of pending stores.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int PW    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          st_valid;
  logic          st_ready;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic [31:0]   st_pc;
  logic [31:0]   ld_addr;
  logic          ld_hit;
  logic [31:0]   ld_data;
  logic          drain_en;
  logic          MemWrite;
  logic [31:0]   pc;
  logic [31:0]   addr;
  logic [31:0]   din;
  logic [PW:0]   count;
  logic          empty;

  store_buffer #(.DEPTH(DEPTH), .PW(PW)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .drain_en(drain_en), .MemWrite(MemWrite),
    .pc(pc), .addr(addr), .din(din),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] p;
  } store_t;

  store_t      pend[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the pending-store queue, then apply the
  // coming clock edge to the queue. Called after inputs are driven.
  task automatic tick();
    logic        exp_mw;
    logic        exp_hit;
    logic [31:0] exp_ld;
    logic        do_enq;
    #1;
    exp_mw = drain_en && (pend.size() != 0);
    check("count",    32'(count),    32'(pend.size()));
    check("empty",    32'(empty),    32'(pend.size() == 0));
    check("st_ready", 32'(st_ready), 32'(pend.size() < DEPTH));
    check("MemWrite", 32'(MemWrite), 32'(exp_mw));
    if (exp_mw) begin
      check("addr", addr, pend[0].a);
      check("din",  din,  pend[0].d);
      check("pc",   pc,   pend[0].p);
    end
    exp_hit = 1'b0;
    exp_ld  = '0;
    foreach (pend[i]) begin
      if (pend[i].a == ld_addr) begin
        exp_hit = 1'b1;
        exp_ld  = pend[i].d;
      end
    end
    check("ld_hit",  32'(ld_hit), 32'(exp_hit));
    check("ld_data", ld_data,     exp_ld);
    do_enq = st_valid && (pend.size() < DEPTH);
    if (exp_mw) void'(pend.pop_front());
    if (do_enq) pend.push_back('{a: st_addr, d: st_data, p: st_pc});
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    pend.delete();
    check("rst_count",    32'(count),    32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_MemWrite", 32'(MemWrite), 32'd0);
    check("rst_st_ready", 32'(st_ready), 32'd1);
    check("rst_ld_hit",   32'(ld_hit),   32'd0);
    check("rst_ld_data",  ld_data,       32'd0);
    #1;
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_pc    = p;
    tick();
    st_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_pc = '0;
    ld_addr = 32'hFFFF_FFFF; drain_en = 1'b0;
    @(negedge clk);
    do_reset();

    // Single store retires on the following edge.
    drain_en = 1'b1;
    push(32'h10, 32'hAAAA_0001, 32'h3000);
    #1;
    check("t1_MemWrite", 32'(MemWrite), 32'd1);
    check("t1_addr", addr, 32'h10);
    check("t1_din",  din,  32'hAAAA_0001);
    check("t1_pc",   pc,   32'h3000);
    tick();
    #1;
    check("t1_empty", 32'(empty), 32'd1);
    check("t1_count", 32'(count), 32'd0);

    // Fill while held, 5th store dropped, then drain in order.
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) push(32'(i), 32'h100 + 32'(i), 32'h4000 + 32'(4*i));
    #1;
    check("t2_count", 32'(count),    32'd4);
    check("t2_ready", 32'(st_ready), 32'd0);
    push(32'h5, 32'hDEAD, 32'h4010);
    drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_order_addr", addr, 32'(i));
      check("t2_order_din",  din,  32'h100 + 32'(i));
      tick();
    end
    #1;
    check("t2_empty", 32'(empty), 32'd1);

    // Youngest matching store is forwarded.
    drain_en = 1'b0;
    push(32'h20, 32'h11, 32'h5000);
    push(32'h24, 32'h22, 32'h5004);
    push(32'h20, 32'h33, 32'h5008);
    ld_addr = 32'h20;
    #1;
    check("t3_hit",  32'(ld_hit), 32'd1);
    check("t3_data", ld_data,     32'h33);
    tick();
    ld_addr = 32'h28;
    #1;
    check("t3_miss_hit",  32'(ld_hit), 32'd0);
    check("t3_miss_data", ld_data,     32'd0);
    tick();
    drain_en = 1'b1;
    while (pend.size() != 0) tick();

    // Back-to-back stream: occupancy settles at one entry.
    for (int i = 0; i < 10; i++) begin
      push(32'h40 + 32'(i), 32'hB000 + 32'(i), 32'h6000 + 32'(4*i));
      #1;
      check("t4_count", 32'(count),    32'd1);
      check("t4_ready", 32'(st_ready), 32'd1);
    end
    tick();

    // Full buffer with drain and store both asserted.
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h80 + 32'(i), 32'hC000 + 32'(i), 32'h7000);
    drain_en = 1'b1;
    push(32'h90, 32'hC100, 32'h7100);
    #1;
    check("t5_count_a", 32'(count), 32'd3);
    push(32'h94, 32'hC101, 32'h7104);
    #1;
    check("t5_count_b", 32'(count), 32'd3);
    while (pend.size() != 0) tick();

    // Asynchronous reset mid-cycle discards pending stores.
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) push(32'hA0 + 32'(i), 32'hD000 + 32'(i), 32'h8000);
    drain_en = 1'b1;
    #1;
    check("t6_pre_MemWrite", 32'(MemWrite), 32'd1);
    do_reset();
    for (int i = 0; i < 3; i++) tick();

    // Randomized traffic over a small address range to exercise forwarding.
    for (int i = 0; i < 400; i++) begin
      st_valid = ($urandom_range(0, 99) < 60);
      drain_en = ($urandom_range(0, 99) < 50);
      st_addr  = 32'($urandom_range(0, 7));
      st_data  = $urandom;
      st_pc    = 32'h9000 + 32'(4*i);
      ld_addr  = 32'($urandom_range(0, 8));
      if ($urandom_range(0, 99) == 0) do_reset();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
